// File: rtl/dbus_periph_pkg.sv
// Shared register-map offsets and bit positions for the dbus_periph data-bus responder.
package dbus_periph_pkg;

    localparam logic [7:0] OFF_COUNT  = 8'h00;
    localparam logic [7:0] OFF_CMP    = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_TXDATA = 8'h0C;
    localparam logic [7:0] OFF_CTRL   = 8'h10;

    localparam int unsigned ST_FLAG    = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_EMPTY   = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;

    localparam int unsigned CTRL_CNT_EN = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

endpackage

// File: rtl/periph_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers; the caller only asserts push when a slot is free.
module periph_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (push) begin
            mem_d[wptr_q[AW-1:0]] = din;
            wptr_d                = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: contents are unobservable while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/dbus_periph.sv
// Data-bus responder: 32-bit compare timer with interrupt plus a byte TX FIFO on a
// valid/ready stream. Reads are combinational and side-effect free.
module dbus_periph
    import dbus_periph_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'hFFFF_FF00,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]   count_q, count_d, cmp_q, cmp_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          flag_q, flag_d, ovf_q, ovf_d;
    logic [7:0]    off;
    logic          wr_en;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop, tx_req;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          unused_adr;

    assign hit        = (DataAdr[31:8] == BASE[31:8]);
    assign off        = {DataAdr[7:2], 2'b00};
    assign unused_adr = ^DataAdr[1:0];
    assign wr_en      = MemWrite & hit;

    assign tx_req    = wr_en && (off == OFF_TXDATA);
    assign out_valid = ~fifo_empty;
    assign fifo_pop  = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign fifo_push = tx_req & (~fifo_full | fifo_pop);
    assign irq       = flag_q & ctrl_q[CTRL_IRQ_EN];

    always_comb begin
        status                      = '0;
        status[ST_FLAG]             = flag_q;
        status[ST_FULL]             = fifo_full;
        status[ST_EMPTY]            = fifo_empty;
        status[ST_OVF]              = ovf_q;
        status[ST_CNT_LSB +: 4]     = 4'(fifo_count);
    end

    always_comb begin
        ReadData = '0;
        if (hit) begin
            case (off)
                OFF_COUNT:  ReadData = count_q;
                OFF_CMP:    ReadData = cmp_q;
                OFF_STATUS: ReadData = status;
                OFF_CTRL:   ReadData = {30'd0, ctrl_q};
                default:    ReadData = '0;
            endcase
        end
    end

    always_comb begin
        count_d = count_q + {31'd0, ctrl_q[CTRL_CNT_EN]};
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        flag_d  = flag_q;
        ovf_d   = ovf_q;
        if (wr_en) begin
            case (off)
                OFF_COUNT: count_d = WriteData;
                OFF_CMP:   cmp_d   = WriteData;
                OFF_CTRL:  ctrl_d  = WriteData[1:0];
                OFF_STATUS: begin
                    if (WriteData[ST_FLAG]) flag_d = 1'b0;
                    if (WriteData[ST_OVF])  ovf_d  = 1'b0;
                end
                default: ;
            endcase
        end
        // Sets follow the clears so a coincident set wins.
        if (ctrl_q[CTRL_CNT_EN] && (count_q == cmp_q)) flag_d = 1'b1;
        if (tx_req && fifo_full && !fifo_pop)          ovf_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            cmp_q   <= 32'hFFFF_FFFF;
            ctrl_q  <= '0;
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
        end
    end

    periph_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (WriteData[7:0]),
        .pop   (fifo_pop),
        .dout  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
